// File: rtl/trdb_pkg.sv
// rtl/trdb_pkg.sv - shared widths, header layout, FSM states and packet type for the trace packet serializer (TE_SERIALIZER_LOST_COUNT_EN adds lost-marker states)
package trdb_pkg;

  localparam int DEF_PTYPE_W   = 2;
  localparam int DEF_LEN_W     = 5;
  localparam int DEF_PAYLOAD_W = 248;

  // Header byte layout: {1'b0, length, type}
  localparam int HDR_TYPE_LSB  = 0;
  localparam int HDR_LEN_LSB   = 2;
  localparam int HDR_RSVD_BIT  = 7;

  localparam logic [7:0] LOST_MARKER = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD
`ifdef TE_SERIALIZER_LOST_COUNT_EN
    ,
    ST_LOST_MARK,
    ST_LOST_CNT
`endif
  } state_e;

  typedef struct packed {
    logic [DEF_PTYPE_W-1:0]   ptype;
    logic [DEF_LEN_W-1:0]     length;
    logic [DEF_PAYLOAD_W-1:0] payload;
  } packet_t;

  function automatic logic [7:0] hdr_byte(input logic [DEF_LEN_W-1:0]   len,
                                          input logic [DEF_PTYPE_W-1:0] ptype);
    logic [7:0] b;
    b = '0;
    b[HDR_LEN_LSB +: DEF_LEN_W]    = len;
    b[HDR_TYPE_LSB +: DEF_PTYPE_W] = ptype;
    b[HDR_RSVD_BIT]                = 1'b0;
    return b;
  endfunction

  function automatic logic [7:0] payload_byte(input logic [DEF_PAYLOAD_W-1:0] payload,
                                              input logic [DEF_LEN_W-1:0]     idx);
    logic [DEF_PAYLOAD_W-1:0] sh;
    sh = payload >> {idx, 3'b000};
    return sh[7:0];
  endfunction

endpackage

// File: rtl/te_packet_fifo.sv
// rtl/te_packet_fifo.sv - synchronous FIFO of whole trace packets with flush
module te_packet_fifo
  import trdb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    clear_i,
  input  logic    push_i,
  input  packet_t push_pkt_i,
  input  logic    pop_i,
  output packet_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = $clog2(DEPTH);

  packet_t       mem_q [DEPTH];
  logic [AW:0]   wr_q;
  logic [AW:0]   rd_q;
  logic          do_push;
  logic          do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i & ~full_o & ~clear_i;
  assign do_pop  = pop_i & ~empty_o & ~clear_i;
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // Pointer update; flush wins over push and pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clear_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Packet storage, write port only
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_pkt_i;
  end

endmodule

// File: rtl/te_packet_serializer.sv
// rtl/te_packet_serializer.sv - buffers encoder packets and streams them as header + LSB-first payload bytes (TE_SERIALIZER_LOST_COUNT_EN adds lost_count_o and marker bytes)
module te_packet_serializer
  import trdb_pkg::*;
#(
  parameter int PTYPE_W    = DEF_PTYPE_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int PAYLOAD_W  = DEF_PAYLOAD_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 packet_valid_i,
  input  logic [PTYPE_W-1:0]   packet_type_i,
  input  logic [LEN_W-1:0]     packet_length_i,
  input  logic [PAYLOAD_W-1:0] packet_payload_i,
  output logic [7:0]           byte_o,
  output logic                 byte_valid_o,
  output logic                 byte_last_o,
  input  logic                 byte_ready_i,
  input  logic                 clear_i,
  output logic                 overflow_o,
  output logic                 busy_o
`ifdef TE_SERIALIZER_LOST_COUNT_EN
  ,
  output logic [7:0]           lost_count_o
`endif
);

  packet_t              push_pkt;
  packet_t              head_pkt;
  packet_t              work_q, work_d;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop, drop, xfer;
  logic                 finish, start;
  state_e               state_q, state_d;
  logic [DEF_LEN_W-1:0] idx_q, idx_d;
  logic [7:0]           byte_q, byte_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 overflow_q;
`ifdef TE_SERIALIZER_LOST_COUNT_EN
  logic [7:0]           lost_q;
  logic [7:0]           snap_q, snap_d;
  logic                 cnt_done;
`endif

  assign push_pkt = '{ptype: packet_type_i, length: packet_length_i, payload: packet_payload_i};
  // Fullness uses the registered count, so a same-cycle pop never rescues a push
  assign drop     = packet_valid_i & fifo_full & ~clear_i;
  assign push     = packet_valid_i & ~fifo_full & ~clear_i;
  assign xfer     = valid_q & byte_ready_i;

  te_packet_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .push_i     (push),
    .push_pkt_i (push_pkt),
    .pop_i      (pop),
    .head_o     (head_pkt),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Next state and next registered byte; start loads the FIFO head so packets chain without a bubble
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    last_d  = last_q;
    pop     = 1'b0;
    finish  = 1'b0;
    start   = 1'b0;
`ifdef TE_SERIALIZER_LOST_COUNT_EN
    snap_d   = snap_q;
    cnt_done = 1'b0;
`endif
    case (state_q)
      ST_IDLE: start = ~fifo_empty;
      ST_HEADER: begin
        if (xfer) begin
          if (work_q.length != '0) begin
            state_d = ST_PAYLOAD;
            idx_d   = '0;
            byte_d  = payload_byte(work_q.payload, '0);
            last_d  = (work_q.length == DEF_LEN_W'(1));
          end else begin
            finish = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (xfer) begin
          if (last_q) begin
            finish = 1'b1;
          end else begin
            idx_d  = idx_q + 1'b1;
            byte_d = payload_byte(work_q.payload, idx_d);
            last_d = (idx_d == work_q.length - 1'b1);
          end
        end
      end
`ifdef TE_SERIALIZER_LOST_COUNT_EN
      ST_LOST_MARK: begin
        if (xfer) begin
          state_d = ST_LOST_CNT;
          byte_d  = snap_q;
          last_d  = 1'b0;
        end
      end
      ST_LOST_CNT: begin
        if (xfer) begin
          state_d  = ST_HEADER;
          byte_d   = hdr_byte(work_q.length, work_q.ptype);
          last_d   = (work_q.length == '0);
          cnt_done = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      if (!fifo_empty) begin
        start = 1'b1;
      end else begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        byte_d  = '0;
      end
    end

    if (start) begin
      pop     = 1'b1;
      work_d  = head_pkt;
      idx_d   = '0;
      valid_d = 1'b1;
`ifdef TE_SERIALIZER_LOST_COUNT_EN
      if (lost_q != 8'd0) begin
        state_d = ST_LOST_MARK;
        byte_d  = LOST_MARKER;
        last_d  = 1'b0;
        snap_d  = lost_q;
      end else
`endif
      begin
        state_d = ST_HEADER;
        byte_d  = hdr_byte(head_pkt.length, head_pkt.ptype);
        last_d  = (head_pkt.length == '0);
      end
    end
  end

  // FSM, working packet and output byte registers; clear truncates any packet in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      work_q     <= '0;
      idx_q      <= '0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (clear_i) begin
      state_q    <= ST_IDLE;
      work_q     <= '0;
      idx_q      <= '0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      overflow_q <= overflow_q | drop;
    end
  end

`ifdef TE_SERIALIZER_LOST_COUNT_EN
  // Saturating drop counter; restarts once the count byte has been taken by the sink
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lost_q <= '0;
      snap_q <= '0;
    end else if (clear_i) begin
      lost_q <= '0;
      snap_q <= '0;
    end else begin
      snap_q <= snap_d;
      if (cnt_done)                       lost_q <= {7'd0, drop};
      else if (drop && lost_q != 8'hFF)   lost_q <= lost_q + 8'd1;
    end
  end

  assign lost_count_o = lost_q;
`endif

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign byte_last_o  = last_q;
  assign overflow_o   = overflow_q;
  assign busy_o       = ~fifo_empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_te_packet_serializer.sv
// tb/tb_te_packet_serializer.sv - directed self-checking bench for te_packet_serializer
module tb_te_packet_serializer;

  logic         clk_i            = 1'b0;
  logic         rst_ni           = 1'b0;
  logic         packet_valid_i   = 1'b0;
  logic [1:0]   packet_type_i    = '0;
  logic [4:0]   packet_length_i  = '0;
  logic [247:0] packet_payload_i = '0;
  logic         byte_ready_i     = 1'b0;
  logic         clear_i          = 1'b0;
  logic [7:0]   byte_o;
  logic         byte_valid_o;
  logic         byte_last_o;
  logic         overflow_o;
  logic         busy_o;
`ifdef TE_SERIALIZER_LOST_COUNT_EN
  logic [7:0]   lost_count_o;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  te_packet_serializer dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .packet_valid_i   (packet_valid_i),
    .packet_type_i    (packet_type_i),
    .packet_length_i  (packet_length_i),
    .packet_payload_i (packet_payload_i),
    .byte_o           (byte_o),
    .byte_valid_o     (byte_valid_o),
    .byte_last_o      (byte_last_o),
    .byte_ready_i     (byte_ready_i),
    .clear_i          (clear_i),
    .overflow_o       (overflow_o),
    .busy_o           (busy_o)
`ifdef TE_SERIALIZER_LOST_COUNT_EN
    ,
    .lost_count_o     (lost_count_o)
`endif
  );

  task automatic push(input logic [1:0] t, input logic [4:0] l, input logic [247:0] p);
    packet_valid_i   = 1'b1;
    packet_type_i    = t;
    packet_length_i  = l;
    packet_payload_i = p;
    @(negedge clk_i);
    packet_valid_i   = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk_i);
    total_cnt++; if (byte_o !== 8'h00) $display("FAIL rst_byte: got %h want 00", byte_o); else pass_cnt++;
    total_cnt++; if (byte_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", byte_valid_o); else pass_cnt++;
    total_cnt++; if (byte_last_o !== 1'b0) $display("FAIL rst_last: got %b want 0", byte_last_o); else pass_cnt++;
    total_cnt++; if (overflow_o !== 1'b0) $display("FAIL rst_overflow: got %b want 0", overflow_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o); else pass_cnt++;
`ifdef TE_SERIALIZER_LOST_COUNT_EN
    total_cnt++; if (lost_count_o !== 8'd0) $display("FAIL rst_lost: got %0d want 0", lost_count_o); else pass_cnt++;
`endif
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_basic;
    logic [7:0] eb [4];
    logic       el [4];
    eb = '{8'h0E, 8'hAA, 8'hBB, 8'hCC};
    el = '{1'b0, 1'b0, 1'b0, 1'b1};
    byte_ready_i = 1'b1;
    push(2'd2, 5'd3, 248'hCCBBAA);
    total_cnt++; if (byte_valid_o !== 1'b0) $display("FAIL basic_latency1: valid got %b want 0", byte_valid_o); else pass_cnt++;
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (byte_valid_o !== 1'b1 || byte_o !== eb[i] || byte_last_o !== el[i])
        $display("FAIL basic_byte%0d: got v=%b b=%h l=%b want v=1 b=%h l=%b", i, byte_valid_o, byte_o, byte_last_o, eb[i], el[i]);
      else pass_cnt++;
      @(negedge clk_i);
    end
    total_cnt++; if (byte_valid_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL basic_idle: got v=%b busy=%b want 0 0", byte_valid_o, busy_o); else pass_cnt++;
  endtask

  task automatic test_header_only;
    byte_ready_i = 1'b1;
    push(2'd1, 5'd0, 248'h0);
    total_cnt++; if (byte_valid_o !== 1'b0) $display("FAIL hdronly_latency: valid got %b want 0", byte_valid_o); else pass_cnt++;
    @(negedge clk_i);
    total_cnt++; if (byte_valid_o !== 1'b1 || byte_o !== 8'h01 || byte_last_o !== 1'b1)
      $display("FAIL hdronly_byte: got v=%b b=%h l=%b want v=1 b=01 l=1", byte_valid_o, byte_o, byte_last_o); else pass_cnt++;
    @(negedge clk_i);
    total_cnt++; if (byte_valid_o !== 1'b0) $display("FAIL hdronly_after: valid got %b want 0", byte_valid_o); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] eb [5];
    logic       el [5];
    eb = '{8'h04, 8'h11, 8'h0B, 8'h22, 8'h33};
    el = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    byte_ready_i = 1'b1;
    push(2'd0, 5'd1, 248'h11);
    push(2'd3, 5'd2, 248'h3322);
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (byte_valid_o !== 1'b1 || byte_o !== eb[i] || byte_last_o !== el[i])
        $display("FAIL b2b_byte%0d: got v=%b b=%h l=%b want v=1 b=%h l=%b", i, byte_valid_o, byte_o, byte_last_o, eb[i], el[i]);
      else pass_cnt++;
      @(negedge clk_i);
    end
    total_cnt++; if (byte_valid_o !== 1'b0) $display("FAIL b2b_end: valid got %b want 0", byte_valid_o); else pass_cnt++;
  endtask

  task automatic test_stall;
    bit stable;
    byte_ready_i = 1'b1;
    push(2'd0, 5'd3, 248'h665544);
    @(negedge clk_i);
    total_cnt++; if (byte_o !== 8'h0C || byte_valid_o !== 1'b1) $display("FAIL stall_hdr: got v=%b b=%h want v=1 b=0C", byte_valid_o, byte_o); else pass_cnt++;
    @(negedge clk_i);
    total_cnt++; if (byte_o !== 8'h44) $display("FAIL stall_b0: got %h want 44", byte_o); else pass_cnt++;
    @(negedge clk_i);
    total_cnt++; if (byte_o !== 8'h55 || byte_last_o !== 1'b0) $display("FAIL stall_b1: got b=%h l=%b want b=55 l=0", byte_o, byte_last_o); else pass_cnt++;
    byte_ready_i = 1'b0;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk_i);
      if (byte_valid_o !== 1'b1 || byte_o !== 8'h55 || byte_last_o !== 1'b0) stable = 1'b0;
    end
    total_cnt++; if (stable !== 1'b1) $display("FAIL stall_hold: got v=%b b=%h l=%b want v=1 b=55 l=0", byte_valid_o, byte_o, byte_last_o); else pass_cnt++;
    byte_ready_i = 1'b1;
    @(negedge clk_i);
    total_cnt++; if (byte_valid_o !== 1'b1 || byte_o !== 8'h66 || byte_last_o !== 1'b1)
      $display("FAIL stall_b2: got v=%b b=%h l=%b want v=1 b=66 l=1", byte_valid_o, byte_o, byte_last_o); else pass_cnt++;
    @(negedge clk_i);
    total_cnt++; if (byte_valid_o !== 1'b0) $display("FAIL stall_end: valid got %b want 0", byte_valid_o); else pass_cnt++;
  endtask

  task automatic test_overflow;
    logic [7:0] exp_b [$];
    logic       exp_l [$];
    logic [7:0] got_b [$];
    logic       got_l [$];
    int         cyc;
`ifdef TE_SERIALIZER_LOST_COUNT_EN
    exp_b = '{8'h00, 8'hFF, 8'h01, 8'h01, 8'h02, 8'h07, 8'h5A, 8'h01};
    exp_l = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`else
    exp_b = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h5A, 8'h01};
    exp_l = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
    byte_ready_i = 1'b0;
    push(2'd0, 5'd0, 248'h0);
    push(2'd1, 5'd0, 248'h0);
    push(2'd2, 5'd0, 248'h0);
    push(2'd3, 5'd1, 248'h5A);
    push(2'd1, 5'd0, 248'h0);
    push(2'd2, 5'd2, 248'hBEEF);
    total_cnt++; if (overflow_o !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b1 || byte_valid_o !== 1'b1 || byte_o !== 8'h00)
      $display("FAIL ovf_head: got busy=%b v=%b b=%h want 1 1 00", busy_o, byte_valid_o, byte_o); else pass_cnt++;
`ifdef TE_SERIALIZER_LOST_COUNT_EN
    total_cnt++; if (lost_count_o !== 8'd1) $display("FAIL ovf_lost: got %0d want 1", lost_count_o); else pass_cnt++;
`endif
    byte_ready_i = 1'b1;
    cyc = 0;
    while (byte_valid_o === 1'b1 && cyc < 40) begin
      got_b.push_back(byte_o);
      got_l.push_back(byte_last_o);
      @(negedge clk_i);
      cyc++;
    end
    total_cnt++; if (got_b.size() !== exp_b.size())
      $display("FAIL ovf_count: got %0d bytes want %0d", got_b.size(), exp_b.size()); else pass_cnt++;
    for (int i = 0; i < exp_b.size(); i++) begin
      total_cnt++;
      if (i >= got_b.size()) $display("FAIL ovf_byte%0d: got none want b=%h l=%b", i, exp_b[i], exp_l[i]);
      else if (got_b[i] !== exp_b[i] || got_l[i] !== exp_l[i])
        $display("FAIL ovf_byte%0d: got b=%h l=%b want b=%h l=%b", i, got_b[i], got_l[i], exp_b[i], exp_l[i]);
      else pass_cnt++;
    end
    total_cnt++; if (busy_o !== 1'b0 || overflow_o !== 1'b1)
      $display("FAIL ovf_drained: got busy=%b ovf=%b want 0 1", busy_o, overflow_o); else pass_cnt++;
`ifdef TE_SERIALIZER_LOST_COUNT_EN
    total_cnt++; if (lost_count_o !== 8'd0) $display("FAIL ovf_lost_reset: got %0d want 0", lost_count_o); else pass_cnt++;
`endif
  endtask

  task automatic test_clear;
    byte_ready_i = 1'b1;
    push(2'd1, 5'd3, 248'h030201);
    @(negedge clk_i);
    total_cnt++; if (byte_o !== 8'h0D || byte_valid_o !== 1'b1) $display("FAIL clr_hdr: got v=%b b=%h want v=1 b=0D", byte_valid_o, byte_o); else pass_cnt++;
    @(negedge clk_i);
    total_cnt++; if (byte_o !== 8'h01) $display("FAIL clr_b0: got %h want 01", byte_o); else pass_cnt++;
    clear_i          = 1'b1;
    packet_valid_i   = 1'b1;
    packet_type_i    = 2'd2;
    packet_length_i  = 5'd0;
    packet_payload_i = '0;
    @(negedge clk_i);
    clear_i        = 1'b0;
    packet_valid_i = 1'b0;
    total_cnt++; if (byte_valid_o !== 1'b0 || byte_last_o !== 1'b0 || busy_o !== 1'b0 || overflow_o !== 1'b0)
      $display("FAIL clr_state: got v=%b l=%b busy=%b ovf=%b want 0 0 0 0", byte_valid_o, byte_last_o, busy_o, overflow_o); else pass_cnt++;
`ifdef TE_SERIALIZER_LOST_COUNT_EN
    total_cnt++; if (lost_count_o !== 8'd0) $display("FAIL clr_lost: got %0d want 0", lost_count_o); else pass_cnt++;
`endif
    push(2'd2, 5'd1, 248'h77);
    total_cnt++; if (byte_valid_o !== 1'b0) $display("FAIL clr_repush_latency: valid got %b want 0", byte_valid_o); else pass_cnt++;
    @(negedge clk_i);
    total_cnt++; if (byte_valid_o !== 1'b1 || byte_o !== 8'h06 || byte_last_o !== 1'b0)
      $display("FAIL clr_repush_hdr: got v=%b b=%h l=%b want v=1 b=06 l=0", byte_valid_o, byte_o, byte_last_o); else pass_cnt++;
    @(negedge clk_i);
    total_cnt++; if (byte_valid_o !== 1'b1 || byte_o !== 8'h77 || byte_last_o !== 1'b1)
      $display("FAIL clr_repush_b0: got v=%b b=%h l=%b want v=1 b=77 l=1", byte_valid_o, byte_o, byte_last_o); else pass_cnt++;
    @(negedge clk_i);
    total_cnt++; if (byte_valid_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL clr_repush_end: got v=%b busy=%b want 0 0", byte_valid_o, busy_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_header_only();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_clear();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
